// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
// The state encoding is fixed binary so it stays stable across tools.
package seq_det_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S1     = 3'd1,
        S10    = 3'd2,
        S101   = 3'd3,
        DETECT = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN     = 4'b1011;
    localparam int         PATTERN_LEN = 4;

endpackage

// File: rtl/seq_detector.sv
// Moore detector for serial pattern 1011, MSB first.
// The out flag is decoded from the state register only.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    // Plain vectors so that unreachable codes remain representable.
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_S1     = S1;
    localparam logic [2:0] ST_S10    = S10;
    localparam logic [2:0] ST_S101   = S101;
    localparam logic [2:0] ST_DETECT = DETECT;

    logic [2:0] state;
    logic [2:0] nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = ST_IDLE;
        case (state)
            ST_IDLE:   nxt = in ? ST_S1     : ST_IDLE;
            ST_S1:     nxt = in ? ST_S1     : ST_S10;
            ST_S10:    nxt = in ? ST_S101   : ST_IDLE;
            ST_S101:   nxt = in ? ST_DETECT : ST_S10;
            // Trailing 1 of a match can seed "10" only when overlapping.
            ST_DETECT: nxt = in ? ST_S1 : (OVERLAP ? ST_S10 : ST_IDLE);
            default:   nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out = (state == ST_DETECT);
    end

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector, both OVERLAP settings.
// A history-based model predicts each cycle's out flag.
module tb_seq_detector;
    import seq_det_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in  = 1'b0;
    logic out1;
    logic out0;

    always #5 clk = ~clk;

    seq_detector #(.OVERLAP(1'b1)) dut1 (
        .clk(clk),
        .rst(rst),
        .in (in),
        .out(out1)
    );

    seq_detector #(.OVERLAP(1'b0)) dut0 (
        .clk(clk),
        .rst(rst),
        .in (in),
        .out(out0)
    );

    typedef struct {
        logic  e1;
        logic  e0;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   pq[$];

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] h1;
    logic [3:0] h0;
    int c1;
    int c0;
    int p1;
    int p0;
    int cyc;

    function automatic void model_reset();
        h1  = 4'd0;
        h0  = 4'd0;
        c1  = 0;
        c0  = 0;
        p1  = 0;
        p0  = 0;
        cyc = 0;
        pq.delete();
    endfunction

    // One serial bit: predict, push, clock, pop and compare.
    task automatic step(input logic b, input string tag);
        exp_t e;
        @(negedge clk);
        in = b;
        h1 = {h1[2:0], b};
        h0 = {h0[2:0], b};
        c1++;
        c0++;
        e.e1 = (c1 >= PATTERN_LEN) && (h1 == PATTERN);
        e.e0 = (c0 >= PATTERN_LEN) && (h0 == PATTERN);
        if (e.e0) c0 = 0;
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sbq.pop_front();
        compared++;
        if (out1 !== e.e1) begin
            mismatched++;
            $display("FAIL %s bit%0d ovl1: out=%b expected %b",
                     e.tag, cyc, out1, e.e1);
        end
        compared++;
        if (out0 !== e.e0) begin
            mismatched++;
            $display("FAIL %s bit%0d ovl0: out=%b expected %b",
                     e.tag, cyc, out0, e.e0);
        end
        if (out1 === 1'b1) begin
            p1++;
            pq.push_back(cyc);
        end
        if (out0 === 1'b1) p0++;
    endtask

    task automatic quick_reset();
        @(negedge clk);
        rst = 1'b0;
        in  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic run(input logic bits[$], input string tag);
        foreach (bits[i]) step(bits[i], tag);
    endtask

    task automatic check_cnt(input int got, input int want,
                             input string tag);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in = ~in;
            @(posedge clk);
            #1;
            compared++;
            if (out1 !== 1'b0 || out0 !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_out: out=%b/%b expected 0/0",
                         out1, out0);
            end
            compared++;
            if (dut1.state !== 3'(IDLE) || dut0.state !== 3'(IDLE)) begin
                mismatched++;
                $display("FAIL reset_state: state=%0d/%0d expected %0d",
                         dut1.state, dut0.state, 3'(IDLE));
            end
        end
        rst = 1'b1;
        model_reset();
        step(1'b0, "post_reset");
        step(1'b0, "post_reset");
    endtask

    task automatic test_basic();
        quick_reset();
        run('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
              1'b1, 1'b1, 1'b1, 1'b0}, "basic");
        check_cnt(p1, 1, "basic_pulses1");
        check_cnt(pq.size() > 0 ? pq[0] : -1, 7, "basic_pulse_pos");
        check_cnt(int'(dut1.state), int'(S10), "basic_final_state");
    endtask

    task automatic test_overlap();
        quick_reset();
        run('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}, "overlap");
        check_cnt(p1, 2, "overlap_pulses_ovl1");
        check_cnt(p0, 1, "overlap_pulses_ovl0");
    endtask

    task automatic test_near_miss();
        quick_reset();
        run('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, "near_miss");
        check_cnt(p1, 0, "near_miss_ovl1");
        check_cnt(p0, 0, "near_miss_ovl0");
    endtask

    task automatic test_async_reset();
        quick_reset();
        run('{1'b1, 1'b0, 1'b1}, "async_pre");
        check_cnt(int'(dut1.state), int'(S101), "async_pre_state");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (dut1.state !== 3'(IDLE) || dut0.state !== 3'(IDLE)) begin
            mismatched++;
            $display("FAIL async_state: state=%0d/%0d expected %0d",
                     dut1.state, dut0.state, 3'(IDLE));
        end
        compared++;
        if (out1 !== 1'b0 || out0 !== 1'b0) begin
            mismatched++;
            $display("FAIL async_out: out=%b/%b expected 0/0", out1, out0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step(1'b1, "async_post");
        check_cnt(p1, 0, "async_no_pulse");
        run('{1'b1, 1'b0, 1'b1, 1'b1}, "async_full");
        check_cnt(p1, 1, "async_full_pulse");
    endtask

    task automatic test_back_to_back();
        quick_reset();
        run('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
              1'b1, 1'b0, 1'b1, 1'b1}, "b2b");
        check_cnt(p1, 3, "b2b_pulses");
        if (pq.size() == 3) begin
            check_cnt(pq[1] - pq[0], 3, "b2b_gap1");
            check_cnt(pq[2] - pq[1], 3, "b2b_gap2");
        end
        step(1'b0, "b2b_tail");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overlap();
        test_near_miss();
        test_async_reset();
        test_back_to_back();
        check_cnt(sbq.size(), 0, "scoreboard_empty");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
